// File: rtl/fir_out_buffer_if.sv
// Sample stream bundle between FIR_filter, the output buffer and its consumer.
// The producer/consumer side uses the master modport; the buffer uses slave.
interface fir_out_buffer_if #(
    parameter int unsigned DataW = 14
);
    logic             vin;
    logic [DataW-1:0] din;
    logic             ready;
    logic             vout;
    logic [DataW-1:0] dout;

    modport master (
        output vin,
        output din,
        output ready,
        input  vout,
        input  dout
    );

    modport slave (
        input  vin,
        input  din,
        input  ready,
        output vout,
        output dout
    );
endinterface

// File: rtl/fir_out_buffer.sv
// Elastic FIFO plus registered output stage behind FIR_filter; flags dropped samples.
// Optional FIR_BUF_STATS_EN adds accepted-sample and dropped-sample counters.
module fir_out_buffer #(
    parameter int unsigned DataW = 14,
    parameter int unsigned Depth = 8,
    parameter int unsigned AddrW = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_out_buffer_if.slave      bus,
    output logic [AddrW:0]       count,
    output logic                 full,
    output logic                 ovf,
`ifdef FIR_BUF_STATS_EN
    output logic [31:0]          samples_in,
    output logic [15:0]          samples_drop,
`endif
    input  logic                 ovf_clr
);

    localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(Depth);

    logic [DataW-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             vout_q, vout_d;
    logic [DataW-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             full_now;
    logic             push;
    logic             pop;
    logic             drop;

    // Pop refills the output register whenever it is empty or being taken.
    always_comb begin
        full_now = (count_q == DepthCnt);
        pop      = (count_q != '0) && (!vout_q || bus.ready);
        push     = bus.vin && (!full_now || pop);
        drop     = bus.vin && full_now && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AddrW + 1)'(push) - (AddrW + 1)'(pop);
        vout_d   = vout_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AddrW'(1);
            dout_d   = mem_q[rd_ptr_q];
            vout_d   = 1'b1;
        end else if (vout_q && bus.ready) begin
            vout_d = 1'b0;
        end

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vout_q   <= 1'b0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            vout_q   <= vout_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.din;
        end
    end

    assign bus.vout = vout_q;
    assign bus.dout = dout_q;
    assign count    = count_q;
    assign full     = full_now;
    assign ovf      = ovf_q;

`ifdef FIR_BUF_STATS_EN
    logic [31:0] samples_in_q, samples_in_d;
    logic [15:0] samples_drop_q, samples_drop_d;
    logic [15:0] drop_base;

    // Clear first, then count, so a coincident drop leaves the counter at 1.
    always_comb begin
        samples_in_d   = samples_in_q + 32'(push);
        drop_base      = ovf_clr ? 16'h0000 : samples_drop_q;
        samples_drop_d = drop_base;
        if (drop && (drop_base != 16'hFFFF)) begin
            samples_drop_d = drop_base + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_in_q   <= '0;
            samples_drop_q <= '0;
        end else begin
            samples_in_q   <= samples_in_d;
            samples_drop_q <= samples_drop_d;
        end
    end

    assign samples_in   = samples_in_q;
    assign samples_drop = samples_drop_q;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench for fir_out_buffer: stimulus queues expected samples, a negedge
// monitor pops and compares each sample the consumer takes.
module tb_fir_out_buffer;

    localparam int unsigned DataW = 14;
    localparam int unsigned Depth = 8;
    localparam int unsigned AddrW = 3;

    logic             clk;
    logic             rst_n;
    logic [AddrW:0]   count;
    logic             full;
    logic             ovf;
    logic             ovf_clr;
`ifdef FIR_BUF_STATS_EN
    logic [31:0]      samples_in;
    logic [15:0]      samples_drop;
`endif

    fir_out_buffer_if #(.DataW(DataW)) bus ();

    fir_out_buffer #(
        .DataW(DataW),
        .Depth(Depth),
        .AddrW(AddrW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .count        (count),
        .full         (full),
        .ovf          (ovf),
`ifdef FIR_BUF_STATS_EN
        .samples_in   (samples_in),
        .samples_drop (samples_drop),
`endif
        .ovf_clr      (ovf_clr)
    );

    int checks   = 0;
    int failures = 0;

    logic [DataW-1:0] sb [$];
    logic             stall_prev = 1'b0;
    logic [DataW-1:0] stall_val  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a sample the buffer must accept and present it for the next edge.
    task automatic send(input logic [DataW-1:0] d);
        bus.vin = 1'b1;
        bus.din = d;
        sb.push_back(d);
    endtask

    task automatic drain(input string name);
        int n;
        bus.vin   = 1'b0;
        bus.ready = 1'b1;
        n = 0;
        while ((count != '0 || bus.vout) && n < 40) begin
            tick();
            n++;
        end
        check({name, "_drain_done"}, 32'((count == '0) && !bus.vout), 32'd1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Consumer-side monitor: one comparison per taken sample, plus hold checks while stalled.
    always @(negedge clk) begin
        if (rst_n && bus.vout) begin
            if (stall_prev) begin
                check("stall_hold", 32'(bus.dout), 32'(stall_val));
            end
            if (bus.ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(bus.dout), 32'hFFFF_FFFF);
                end else begin
                    check("out_data", 32'(bus.dout), 32'(sb.pop_front()));
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = 1'b1;
                stall_val  = bus.dout;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    logic vin_pat [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_n     = 1'b0;
        bus.vin   = 1'b0;
        bus.din   = '0;
        bus.ready = 1'b0;
        ovf_clr   = 1'b0;
        #3;
        check("rst_count", 32'(count), 32'd0);
        check("rst_vout", 32'(bus.vout), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        #20 rst_n = 1'b1;
        tick();

        // Pass-through with constant ready.
        bus.ready = 1'b1;
        send(14'h0001);
        tick();
        check("pt_lat_vout0", 32'(bus.vout), 32'd0);
        check("pt_count0", 32'(count), 32'd1);
        send(14'h1FFF);
        tick();
        check("pt_lat_vout1", 32'(bus.vout), 32'd1);
        check("pt_dout0", 32'(bus.dout), 32'h0001);
        check("pt_count1", 32'(count), 32'd1);
        send(14'h2000);
        tick();
        check("pt_dout1", 32'(bus.dout), 32'h1FFF);
        check("pt_count2", 32'(count), 32'd1);
        bus.vin = 1'b0;
        tick();
        check("pt_dout2", 32'(bus.dout), 32'h2000);
        check("pt_count3", 32'(count), 32'd0);
        tick();
        check("pt_vout_end", 32'(bus.vout), 32'd0);
        check("pt_dout_hold", 32'(bus.dout), 32'h2000);

        // Fill with consumer stalled, then one drop.
        bus.ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            send(14'(i));
            tick();
        end
        check("fill_vout", 32'(bus.vout), 32'd1);
        check("fill_dout", 32'(bus.dout), 32'd1);
        check("fill_count", 32'(count), 32'd8);
        check("fill_full", 32'(full), 32'd1);
        check("fill_ovf", 32'(ovf), 32'd0);
`ifdef FIR_BUF_STATS_EN
        check("stats_in", samples_in, 32'd12);
`endif
        bus.vin = 1'b1;
        bus.din = 14'd10;
        tick();
        check("drop_ovf", 32'(ovf), 32'd1);
        check("drop_count", 32'(count), 32'd8);

        // Full with simultaneous pop and push.
        bus.ready = 1'b1;
        send(14'h00AA);
        tick();
        check("sim_count", 32'(count), 32'd8);
        check("sim_full", 32'(full), 32'd1);
        check("sim_ovf", 32'(ovf), 32'd1);
        check("sim_dout", 32'(bus.dout), 32'd2);
        drain("sim");

        // Overflow clear, plain and coincident with a drop.
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_ovf", 32'(ovf), 32'd0);
        bus.ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send(14'(14'h0100 + i));
            tick();
        end
        check("clr_full", 32'(full), 32'd1);
        bus.vin = 1'b1;
        bus.din = 14'h01FF;
        ovf_clr = 1'b1;
        tick();
        check("clr_coinc_ovf", 32'(ovf), 32'd1);
        check("clr_coinc_count", 32'(count), 32'd8);
`ifdef FIR_BUF_STATS_EN
        check("stats_drop", 32'(samples_drop), 32'd1);
`endif
        bus.vin = 1'b0;
        tick();
        ovf_clr = 1'b0;
        check("clr_again_ovf", 32'(ovf), 32'd0);
        drain("clr");

        // Bursty input against a toggling consumer.
        for (int i = 0; i < 11; i++) begin
            bus.ready = (i % 2 == 0);
            if (vin_pat[i]) begin
                send(14'(14'h3000 + i));
            end else begin
                bus.vin = 1'b0;
                bus.din = 14'h3FFF;
            end
            tick();
        end
        drain("burst");
        check("burst_ovf", 32'(ovf), 32'd0);

        // Asynchronous reset mid-stream with five samples buffered.
        bus.ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(14'(14'h0500 + i));
            tick();
        end
        bus.vin = 1'b0;
        check("pre_rst_count", 32'(count), 32'd5);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_vout", 32'(bus.vout), 32'd0);
        check("arst_dout", 32'(bus.dout), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        check("arst_full", 32'(full), 32'd0);
`ifdef FIR_BUF_STATS_EN
        check("arst_stats_in", samples_in, 32'd0);
`endif
        #10 rst_n = 1'b1;
        tick();
        bus.ready = 1'b1;
        send(14'h1234);
        tick();
        bus.vin = 1'b0;
        check("post_rst_count", 32'(count), 32'd1);
        drain("post_rst");

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
